// File: rtl/sprite_mem_arbiter_if.sv
// Bus bundle between the sprite texture RAM arbiter, its two requesters and the RAM.
// The arbiter takes the slave view; the environment (renderer, loader, RAM) takes master.
interface sprite_mem_arbiter_if #(
  parameter int TW = 6
);
  logic          r_req;
  logic [5:0]    r_col;
  logic [5:0]    r_row;
  logic          r_gnt;
  logic          r_valid;
  logic [TW-1:0] r_data;

  logic          l_valid;
  logic [11:0]   l_addr;
  logic [TW-1:0] l_data;
  logic          l_ready;

  logic [11:0]   mem_addr;
  logic          mem_we;
  logic [TW-1:0] mem_wdata;
  logic [TW-1:0] mem_rdata;

  modport slave (
    input  r_req, r_col, r_row, l_valid, l_addr, l_data, mem_rdata,
    output r_gnt, r_valid, r_data, l_ready, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output r_req, r_col, r_row, l_valid, l_addr, l_data, mem_rdata,
    input  r_gnt, r_valid, r_data, l_ready, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/sprite_mem_arbiter.sv
// Shares one single-port 64x64 sprite texture RAM between renderer reads and buffered
// loader writes; reads win unless a queued write has waited STARVE_LIMIT read grants.
module sprite_mem_arbiter #(
  parameter int CHANNEL_BITS = 2,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                clk,
  input  logic                reset_n,
  sprite_mem_arbiter_if.slave bus
);

  localparam int         TW    = 3 * CHANNEL_BITS;
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [11:0]   fifo_addr [2];
  logic [TW-1:0] fifo_data [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;
  logic [7:0]    starve_cnt;
  logic [11:0]   last_raddr;
  logic          r_valid_q;

  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          pop;
  logic          w_gnt;
  logic          r_gnt;
  logic [11:0]   r_addr;

  // Arbitration uses only registered state plus r_req, so grants are glitch-free per cycle.
  // r_gnt is gated by reset_n because reset is asynchronous and r_req may be high meanwhile.
  always_comb begin
    fifo_empty = (count == 2'd0);
    fifo_full  = (count == 2'd2);
    r_addr     = {bus.r_col, bus.r_row};
    w_gnt      = !fifo_empty && (!bus.r_req || (starve_cnt == LIMIT));
    r_gnt      = reset_n && bus.r_req && !w_gnt;
    push       = bus.l_valid && !fifo_full;
    pop        = w_gnt;
  end

  always_comb begin
    bus.mem_we    = w_gnt;
    bus.mem_wdata = fifo_data[rd_ptr];
    bus.mem_addr  = last_raddr;
    if (w_gnt) begin
      bus.mem_addr = fifo_addr[rd_ptr];
    end else if (r_gnt) begin
      bus.mem_addr = r_addr;
    end
  end

  assign bus.r_gnt   = r_gnt;
  assign bus.l_ready = !fifo_full;
  assign bus.r_valid = r_valid_q;
  assign bus.r_data  = bus.mem_rdata[TW-1:0];

  // Payload storage needs no reset: occupancy alone says which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bus.l_addr;
      fifo_data[wr_ptr] <= bus.l_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
      starve_cnt <= 8'd0;
      last_raddr <= 12'd0;
      r_valid_q  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase

      // Counts read grants taken while a write waits; hitting LIMIT forces the write through.
      if (fifo_empty || w_gnt) begin
        starve_cnt <= 8'd0;
      end else if (r_gnt && (starve_cnt != LIMIT)) begin
        starve_cnt <= starve_cnt + 8'd1;
      end

      if (r_gnt) begin
        last_raddr <= r_addr;
      end
      r_valid_q <= r_gnt;
    end
  end

endmodule

// File: doc/sprite_mem_arbiter.md
# sprite_mem_arbiter

Shares one single-port, synchronous-read 64×64 sprite texture RAM between two requesters:
- the renderer, which reads texels during scanout;
- a host loader, which writes texels at runtime.

The block replaces the sim-populated texture store with a RAM that can be filled in the field. It sits between the raycaster pixel pipeline and the texture memory. Renderer reads take priority, and a starvation guard guarantees the loader forward progress.

## Interface
Parameters:
- CHANNEL_BITS, 2: bits per colour channel; texel width TW = 3*CHANNEL_BITS.
- STARVE_LIMIT, 15: cycles a pending write may wait before it pre-empts a read. Legal range 1..255.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- r_req  in  1  renderer read request; held until granted.
- r_col  in  6  texel column.
- r_row  in  6  texel row.
- r_gnt  out  1  combinational; read is issued to RAM this cycle.
- r_valid  out  1  r_data valid; asserted exactly 1 cycle after r_gnt.
- r_data  out  TW  texel read data.
- l_valid  in  1  loader write valid.
- l_addr  in  12  write address {col,row}.
- l_data  in  TW  write data.
- l_ready  out  1  write accepted when l_valid && l_ready.
- mem_addr  out  12  RAM address {col,row}, column-major (col in [11:6]).
- mem_we  out  1  RAM write enable.
- mem_wdata  out  TW  RAM write data.
- mem_rdata  in  TW  RAM read data; 1-cycle synchronous read latency.

## Operation
Write buffer:
- 2-entry FIFO of {addr,data}.
- l_ready = !full (registered occupancy, not dependent on the same-cycle pop).
- A push while full is impossible by construction.
- Push and pop in the same cycle leave occupancy unchanged.

Starvation counter:
- 8-bit starve_cnt.
- Clears when the FIFO is empty or a write is granted.
- Otherwise increments when FIFO is non-empty and a read is granted.
- Saturates at STARVE_LIMIT.

Arbitration is combinational, from the registered state and r_req. Write is granted (w_gnt) when the FIFO is non-empty and either:
- !r_req, or
- starve_cnt == STARVE_LIMIT.

Otherwise r_gnt = r_req.

RAM outputs:
- w_gnt: mem_we=1, mem_addr/mem_wdata = FIFO head; FIFO pops.
- r_gnt: mem_we=0, mem_addr={r_col,r_row}.
- Idle: mem_we=0, mem_addr=last read address (no spurious toggling required; value unconstrained for the verifier).

Read return:
- r_valid is a register = r_gnt delayed 1 cycle.
- r_data = mem_rdata[TW-1:0] passed through, valid only while r_valid.

Ordering and coherency:
- A write and a read to the same address never occur in one cycle.
- A read granted after a write sees the new data.
- Writes retire in acceptance order.

## Timing
Reset (reset_n low, async) clears:
- FIFO (empty), starve_cnt=0, r_valid=0.
- l_ready=1 immediately after reset is applied.
- r_gnt/mem_we=0 during reset.

Latency:
- Read: r_req high in cycle N with no pending writes → r_gnt in N, r_valid/r_data in N+1.
- Back-to-back reads sustain 1 texel/cycle.
- Write: accepted in cycle N → earliest RAM write in N+1 (when r_req low).
- With r_req held continuously, a write reaches RAM no later than STARVE_LIMIT+1 cycles after it is at the FIFO head.
- When a write pre-empts a read, r_gnt=0 that cycle. The renderer holds r_req/r_col/r_row, is granted next cycle, and sees r_valid one cycle later than it otherwise would.

Reset mid-operation:
- Pending FIFO writes are discarded.
- An in-flight r_valid is cancelled.
- The RAM contents are not the block's concern.

## Test plan
- Reset: hold reset_n low 3 cycles with l_valid=1, r_req=1 → r_gnt=0, mem_we=0, r_valid=0, l_ready=1; release → r_gnt=1 same cycle.
- Read latency: preload RAM[{6'd5,6'd9}]=6'h2A, r_req with col=5,row=9 → mem_addr=12'h149 in N, r_valid=1 and r_data=6'h2A in N+1; a 4-read burst gives 4 consecutive r_valid cycles.
- Idle write: r_req=0, write addr 12'h0FF data 6'h15 → mem_we=1 with that addr/data next cycle; subsequent read of 12'h0FF returns 6'h15.
- Starvation, STARVE_LIMIT=15: r_req held continuously, one write queued → 15 read grants, then exactly 1 cycle with mem_we=1 and r_gnt=0, then reads resume; read data stream is uninterrupted apart from that 1-cycle gap.
- FIFO full: r_req held, 3 back-to-back writes → l_ready drops after 2 accepts; the third is accepted only after the first retires; RAM writes occur in order.
- Reset mid-burst: 2 writes queued, r_valid pending, pulse reset_n low → no mem_we afterwards, r_valid=0, FIFO empty, l_ready=1.
